victim_wb_buffer: RTL and testbench

VICTIM_WB_BUFFER -- requirements
Module: victim_wb_buffer

---
 rtl/victim_wb_buffer.sv | 169 ++++++++++++++++
 tb/tb_victim_wb_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_wb_buffer.sv
// victim_wb_buffer
//   Write-back buffer that sits behind the victim cache. Dirty lines displaced
//   from the cache are queued in a small circular FIFO and written to memory
//   one at a time. While a line waits in the buffer, a cache miss can probe it
//   by tag and take the data straight back. A flush request stops new lines
//   from being accepted, lets the queue drain, and then pulses flush_done.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   evict_valid/dirty/tag/data  line offered by the victim cache
//   evict_ready               buffer takes the offer this cycle
//   lookup_tag                miss tag probed by the cache
//   lookup_hit/lookup_data    youngest buffered entry matching lookup_tag
//   mem_wr_req/tag/data       write-back request to memory (head entry)
//   mem_wr_ack                memory accepted the current write
//   flush_req                 one-cycle pulse: drain all entries
//   flush_done                one-cycle pulse: drain complete

module victim_wb_buffer #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int DCACHE_TAG_BITS   = 24,
  parameter int WB_DEPTH          = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evict_valid,
  input  logic                         evict_dirty,
  input  logic [DCACHE_TAG_BITS-1:0]   evict_tag,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data,
  output logic                         evict_ready,
  input  logic [DCACHE_TAG_BITS-1:0]   lookup_tag,
  output logic                         lookup_hit,
  output logic [DCACHE_LINE_WIDTH-1:0] lookup_data,
  output logic                         mem_wr_req,
  output logic [DCACHE_TAG_BITS-1:0]   mem_wr_tag,
  output logic [DCACHE_LINE_WIDTH-1:0] mem_wr_data,
  input  logic                         mem_wr_ack,
  input  logic                         flush_req,
  output logic                         flush_done
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_next;

  logic [DCACHE_TAG_BITS-1:0]   tag_mem  [WB_DEPTH];
  logic [DCACHE_LINE_WIDTH-1:0] data_mem [WB_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             flush_pending;
  logic             push, pop;
  logic [PTR_W-1:0] lookup_idx;

  // Ready depends only on registered state so the cache never sees a
  // combinational path from its own offer back into ready. A full buffer
  // being popped this cycle therefore still reports not-ready.
  assign evict_ready = (count < CNT_W'(WB_DEPTH)) && !flush_pending;

  // Clean lines are handshaken but never stored: memory already holds them.
  assign push = evict_valid && evict_ready && evict_dirty;
  assign pop  = (state == SEND) && mem_wr_ack;

  assign flush_done = flush_pending && (count == '0);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Line storage carries no reset; validity comes entirely from count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr]  <= evict_tag;
      data_mem[wr_ptr] <= evict_data;
    end
  end

  // FIFO bookkeeping. Pointers wrap for free because depth is a power of two.
  // A flush request is only latched when none is outstanding, and the pending
  // flag drops on the same edge that flush_done is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      if (flush_pending) begin
        flush_pending <= (count != '0);
      end else begin
        flush_pending <= flush_req;
      end
    end
  end

  // Write-back FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stay in SEND back-to-back while entries remain after each acknowledge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (pop && (count_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The head entry is presented only while a write is in flight.
  always_comb begin
    mem_wr_req  = 1'b0;
    mem_wr_tag  = '0;
    mem_wr_data = '0;
    if (state == SEND) begin
      mem_wr_req  = 1'b1;
      mem_wr_tag  = tag_mem[rd_ptr];
      mem_wr_data = data_mem[rd_ptr];
    end
  end

  // Scan from oldest to youngest so a later match overrides an earlier one,
  // giving the most recently evicted copy of a tag. The head being popped
  // this cycle is still inside the valid window, so it still hits.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      lookup_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (tag_mem[lookup_idx] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[lookup_idx];
      end
    end
  end

endmodule

// File: tb/tb_victim_wb_buffer.sv
// tb_victim_wb_buffer
//   Self-checking bench for victim_wb_buffer. A queue-based model of the
//   buffer predicts every output each cycle; directed sequences add literal
//   expectations for the key scenarios, followed by a long randomized run.

module tb_victim_wb_buffer;

  localparam int LW    = 128;
  localparam int TW    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          evict_valid;
  logic          evict_dirty;
  logic [TW-1:0] evict_tag;
  logic [LW-1:0] evict_data;
  logic          evict_ready;
  logic [TW-1:0] lookup_tag;
  logic          lookup_hit;
  logic [LW-1:0] lookup_data;
  logic          mem_wr_req;
  logic [TW-1:0] mem_wr_tag;
  logic [LW-1:0] mem_wr_data;
  logic          mem_wr_ack;
  logic          flush_req;
  logic          flush_done;

  victim_wb_buffer #(
    .DCACHE_LINE_WIDTH(LW),
    .DCACHE_TAG_BITS(TW),
    .WB_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .evict_valid(evict_valid),
    .evict_dirty(evict_dirty),
    .evict_tag(evict_tag),
    .evict_data(evict_data),
    .evict_ready(evict_ready),
    .lookup_tag(lookup_tag),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .mem_wr_req(mem_wr_req),
    .mem_wr_tag(mem_wr_tag),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .flush_req(flush_req),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } entry_t;

  // Model state: queued lines oldest first, whether a write is in flight,
  // and whether a flush is outstanding.
  entry_t mq[$];
  bit     m_send;
  bit     m_pend;

  int sz;
  bit m_rdy, m_push, m_pop, m_done;

  task automatic check_output(input string name, input logic [LW-1:0] actual,
                              input logic [LW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Model advance on each rising edge, using the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_pend = 1'b0;
    end else begin
      sz     = mq.size();
      m_rdy  = (sz < DEPTH) && !m_pend;
      m_push = evict_valid && m_rdy && evict_dirty;
      m_pop  = m_send && mem_wr_ack;
      m_done = m_pend && (sz == 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{tag: evict_tag, data: evict_data});
      if (m_send) m_send = !(m_pop && mq.size() == 0);
      else        m_send = (sz > 0);
      m_pend = m_pend ? !m_done : flush_req;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic          e_hit;
      logic [LW-1:0] e_data;
      e_hit  = 1'b0;
      e_data = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].tag == lookup_tag) begin
          e_hit  = 1'b1;
          e_data = mq[i].data;
          break;
        end
      end
      check_output("evict_ready", evict_ready, (mq.size() < DEPTH) && !m_pend);
      check_output("mem_wr_req", mem_wr_req, m_send);
      check_output("flush_done", flush_done, m_pend && (mq.size() == 0));
      check_output("lookup_hit", lookup_hit, e_hit);
      check_output("lookup_data", lookup_data, e_data);
      if (m_send) begin
        check_output("mem_wr_tag", mem_wr_tag, mq[0].tag);
        check_output("mem_wr_data", mem_wr_data, mq[0].data);
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then return shortly after
  // the falling edge so literal checks see this cycle's outputs.
  task automatic apply_stimulus(input logic v, input logic d, input logic [TW-1:0] tag,
                                input logic [LW-1:0] data, input logic ack,
                                input logic fl, input logic [TW-1:0] ltag,
                                input logic r);
    @(posedge clk);
    #1;
    rst         = r;
    evict_valid = v;
    evict_dirty = d;
    evict_tag   = tag;
    evict_data  = data;
    mem_wr_ack  = ack;
    flush_req   = fl;
    lookup_tag  = ltag;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic ack, input logic [TW-1:0] ltag);
    apply_stimulus(1'b0, 1'b0, '0, '0, ack, 1'b0, ltag, 1'b0);
  endtask

  task automatic push_line(input logic [TW-1:0] tag, input logic [LW-1:0] data);
    apply_stimulus(1'b1, 1'b1, tag, data, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) idle_cycle(1'b1, '0);
    idle_cycle(1'b0, '0);
    check_output("drain_idle", mem_wr_req, 1'b0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LW-1:0] da, db;
    rst         = 1'b1;
    evict_valid = 1'b0;
    evict_dirty = 1'b0;
    evict_tag   = '0;
    evict_data  = '0;
    mem_wr_ack  = 1'b0;
    flush_req   = 1'b0;
    lookup_tag  = '0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    check_output("rst_ready", evict_ready, 1'b1);
    check_output("rst_req", mem_wr_req, 1'b0);
    check_output("rst_done", flush_done, 1'b0);
    check_output("rst_hit", lookup_hit, 1'b0);
    check_output("rst_data", lookup_data, '0);
    idle_cycle(1'b0, '0);

    $display("[TB] two-entry write-back");
    push_line(24'h11, 128'h1111);
    push_line(24'h22, 128'h2222);
    idle_cycle(1'b0, '0);
    check_output("wb_req", mem_wr_req, 1'b1);
    check_output("wb_tag0", mem_wr_tag, 24'h11);
    idle_cycle(1'b0, '0);
    check_output("wb_tag0_stable", mem_wr_tag, 24'h11);
    idle_cycle(1'b1, '0);
    check_output("wb_tag0_ack", mem_wr_tag, 24'h11);
    idle_cycle(1'b0, '0);
    check_output("wb_tag1", mem_wr_tag, 24'h22);
    check_output("wb_req1", mem_wr_req, 1'b1);
    idle_cycle(1'b1, '0);
    idle_cycle(1'b0, 24'h22);
    check_output("wb_idle", mem_wr_req, 1'b0);
    check_output("wb_empty_ready", evict_ready, 1'b1);
    check_output("wb_gone", lookup_hit, 1'b0);

    $display("[TB] full buffer");
    for (int i = 0; i < DEPTH; i++) push_line(TW'(24'h51 + i), rand_line());
    apply_stimulus(1'b1, 1'b1, 24'h55, 128'h5555, 1'b0, 1'b0, 24'h55, 1'b0);
    check_output("full_ready", evict_ready, 1'b0);
    idle_cycle(1'b1, 24'h55);
    check_output("full_no5th", lookup_hit, 1'b0);
    check_output("full_ready_ack", evict_ready, 1'b0);
    idle_cycle(1'b0, '0);
    check_output("full_ready_after", evict_ready, 1'b1);
    drain();

    $display("[TB] clean offer");
    apply_stimulus(1'b1, 1'b0, 24'h33, 128'h3333, 1'b0, 1'b0, 24'h33, 1'b0);
    check_output("clean_ready", evict_ready, 1'b1);
    idle_cycle(1'b0, 24'h33);
    check_output("clean_hit", lookup_hit, 1'b0);
    check_output("clean_req", mem_wr_req, 1'b0);
    idle_cycle(1'b0, 24'h33);
    check_output("clean_req2", mem_wr_req, 1'b0);

    $display("[TB] duplicate tag");
    da = 128'hAAAA_0000_AAAA;
    db = 128'hBBBB_0000_BBBB;
    push_line(24'h44, da);
    apply_stimulus(1'b1, 1'b1, 24'h44, db, 1'b0, 1'b0, 24'h44, 1'b0);
    check_output("dup_first_data", lookup_data, da);
    idle_cycle(1'b1, 24'h44);
    check_output("dup_hit", lookup_hit, 1'b1);
    check_output("dup_young", lookup_data, db);
    check_output("dup_head", mem_wr_data, da);
    idle_cycle(1'b0, 24'h44);
    check_output("dup_after_pop", lookup_data, db);
    drain();

    $display("[TB] flush with entries");
    push_line(24'h61, rand_line());
    push_line(24'h62, rand_line());
    push_line(24'h63, rand_line());
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
    check_output("fl_ready_pre", evict_ready, 1'b1);
    apply_stimulus(1'b1, 1'b1, 24'h77, 128'h7777, 1'b1, 1'b0, '0, 1'b0);
    check_output("fl_ready0", evict_ready, 1'b0);
    check_output("fl_done0", flush_done, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
    check_output("fl_done1", flush_done, 1'b0);
    idle_cycle(1'b1, '0);
    check_output("fl_done2", flush_done, 1'b0);
    check_output("fl_ready2", evict_ready, 1'b0);
    idle_cycle(1'b0, '0);
    check_output("fl_done_pulse", flush_done, 1'b1);
    check_output("fl_ready3", evict_ready, 1'b0);
    idle_cycle(1'b0, 24'h77);
    check_output("fl_done_end", flush_done, 1'b0);
    check_output("fl_ready_end", evict_ready, 1'b1);
    check_output("fl_no77", lookup_hit, 1'b0);

    $display("[TB] flush when empty");
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
    idle_cycle(1'b0, '0);
    check_output("efl_done", flush_done, 1'b1);
    idle_cycle(1'b0, '0);
    check_output("efl_done_end", flush_done, 1'b0);

    $display("[TB] reset during write-back");
    push_line(24'h81, rand_line());
    push_line(24'h82, rand_line());
    idle_cycle(1'b0, '0);
    check_output("rs_req", mem_wr_req, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 24'h81, 1'b1);
    idle_cycle(1'b1, 24'h81);
    check_output("rs_req0", mem_wr_req, 1'b0);
    check_output("rs_hit0", lookup_hit, 1'b0);
    check_output("rs_ready", evict_ready, 1'b1);
    idle_cycle(1'b0, 24'h82);
    check_output("rs_req_still0", mem_wr_req, 1'b0);
    check_output("rs_hit_still0", lookup_hit, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 9) < 6,
                     $urandom_range(0, 3) != 0,
                     TW'($urandom_range(0, 7)),
                     rand_line(),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 39) == 0,
                     TW'($urandom_range(0, 7)),
                     $urandom_range(0, 299) == 0);
    end
    idle_cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
